// File: rtl/knn_result_reader_pkg.sv
// Shared types and helpers for the KNN sorted-list readout engine.
package knn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ADV1,
        ST_ADV2,
        ST_DRAIN,
        ST_FIN
    } knn_state_t;

    // An unfilled sorter slot reports an all-ones name; narrower names use the low bits.
    localparam logic [63:0] EMPTY_NAME = '1;

    function automatic logic [31:0] clamp_k(input logic [31:0] k, input logic [31:0] max_mem);
        return (k > max_mem) ? max_mem : k;
    endfunction

endpackage

// File: rtl/knn_result_reader_if.sv
// Sorter read-port bus and the valid/ready result stream of the KNN readout engine.
interface knn_sort_if #(
    parameter int VAL_WIDTH  = 32,
    parameter int NAME_WIDTH = 32
);
    logic [NAME_WIDTH-1:0] sort_name;
    logic [VAL_WIDTH-1:0]  sort_value;
    logic                  sort_rd_en;
    logic                  sort_done;

    modport master (input sort_name, input sort_value, output sort_rd_en, output sort_done);
    modport slave  (output sort_name, output sort_value, input sort_rd_en, input sort_done);
endinterface

interface knn_stream_if #(
    parameter int VAL_WIDTH  = 32,
    parameter int NAME_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [NAME_WIDTH-1:0] m_name;
    logic [VAL_WIDTH-1:0]  m_value;
    logic [31:0]           m_index;
    logic                  m_last;

    modport master (output m_valid, output m_name, output m_value, output m_index,
                    output m_last, input m_ready);
    modport slave  (input m_valid, input m_name, input m_value, input m_index,
                    input m_last, output m_ready);
endinterface

// File: rtl/knn_result_reader_out_reg.sv
// Single-entry valid/ready output register; with KNN_SKIP_EMPTY_EN it adds a one-beat
// lookahead slot so the final beat can be marked last once an empty slot is seen.
module knn_out_reg #(
    parameter int VAL_WIDTH  = 32,
    parameter int NAME_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [NAME_WIDTH-1:0] i_name,
    input  logic [VAL_WIDTH-1:0]  i_value,
    input  logic [31:0]           i_index,
`ifdef KNN_SKIP_EMPTY_EN
    input  logic                  i_flush,
    output logic                  o_hold_valid,
`else
    input  logic                  i_last,
`endif
    output logic                  o_free,
    knn_stream_if.master          m
);

    logic                  r_valid;
    logic [NAME_WIDTH-1:0] r_name;
    logic [VAL_WIDTH-1:0]  r_value;
    logic [31:0]           r_index;
    logic                  r_last;

    assign o_free    = !r_valid || m.m_ready;
    assign m.m_valid = r_valid;
    assign m.m_name  = r_name;
    assign m.m_value = r_value;
    assign m.m_index = r_index;
    assign m.m_last  = r_last;

`ifdef KNN_SKIP_EMPTY_EN
    logic                  r_hold_valid;
    logic [NAME_WIDTH-1:0] r_hold_name;
    logic [VAL_WIDTH-1:0]  r_hold_value;
    logic [31:0]           r_hold_index;

    assign o_hold_valid = r_hold_valid;

    // A new capture pushes the held beat out (not last); a flush emits it as the last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_name       <= '0;
            r_value      <= '0;
            r_index      <= '0;
            r_last       <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_name  <= '0;
            r_hold_value <= '0;
            r_hold_index <= '0;
        end else if (i_load) begin
            r_hold_valid <= 1'b1;
            r_hold_name  <= i_name;
            r_hold_value <= i_value;
            r_hold_index <= i_index;
            if (r_hold_valid) begin
                r_valid <= 1'b1;
                r_name  <= r_hold_name;
                r_value <= r_hold_value;
                r_index <= r_hold_index;
                r_last  <= 1'b0;
            end else if (m.m_ready) begin
                r_valid <= 1'b0;
            end
        end else if (i_flush) begin
            r_hold_valid <= 1'b0;
            r_valid      <= 1'b1;
            r_name       <= r_hold_name;
            r_value      <= r_hold_value;
            r_index      <= r_hold_index;
            r_last       <= 1'b1;
        end else if (m.m_ready) begin
            r_valid <= 1'b0;
        end
    end
`else
    // NOTE: the payload registers are reset as well because every output must read 0 in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_name  <= '0;
            r_value <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_name  <= i_name;
            r_value <= i_value;
            r_index <= i_index;
            r_last  <= i_last;
        end else if (m.m_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/knn_result_reader.sv
// Drains the k nearest entries of the KNN sorter onto a valid/ready stream in rank order.
// Optional KNN_SKIP_EMPTY_EN stops the readout at the first unfilled sorter slot.
module knn_result_reader
    import knn_pkg::*;
#(
    parameter int VAL_WIDTH  = 32,
    parameter int NAME_WIDTH = 32,
    parameter int MAX_MEMORY = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [31:0]   k,
    knn_sort_if.master    sort,
    knn_stream_if.master  m,
    output logic          busy,
    output logic          finish
);

    knn_state_t  r_state;
    knn_state_t  w_state_nxt;
    logic [31:0] r_k_eff;
    logic [31:0] r_idx;
    logic [31:0] w_k_eff;
    logic        w_is_last;
    logic        w_free;
    logic        w_load;

    assign w_k_eff   = clamp_k(k, 32'(MAX_MEMORY));
    assign w_is_last = (r_idx == r_k_eff - 32'd1);

`ifdef KNN_SKIP_EMPTY_EN
    logic w_empty;
    logic w_hold_valid;
    logic w_flush;

    assign w_empty = (sort.sort_name == NAME_WIDTH'(EMPTY_NAME));
`endif

    knn_out_reg #(
        .VAL_WIDTH  (VAL_WIDTH),
        .NAME_WIDTH (NAME_WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_name       (sort.sort_name),
        .i_value      (sort.sort_value),
        .i_index      (r_idx),
`ifdef KNN_SKIP_EMPTY_EN
        .i_flush      (w_flush),
        .o_hold_valid (w_hold_valid),
`else
        .i_last       (w_is_last),
`endif
        .o_free       (w_free),
        .m            (m)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_k_eff <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && start) begin
                r_k_eff <= w_k_eff;
                r_idx   <= '0;
            end else if (r_state == ST_ADV2) begin
                r_idx <= r_idx + 32'd1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_load          = 1'b0;
        sort.sort_rd_en = 1'b0;
        sort.sort_done  = 1'b0;
        busy            = 1'b1;
        finish          = 1'b0;
`ifdef KNN_SKIP_EMPTY_EN
        w_flush         = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (w_k_eff == 32'd0) ? ST_FIN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                sort.sort_done = 1'b1;
                if (w_free) begin
`ifdef KNN_SKIP_EMPTY_EN
                    if (w_empty) begin
                        w_state_nxt = w_hold_valid ? ST_DRAIN : ST_FIN;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = w_is_last ? ST_DRAIN : ST_ADV1;
                    end
`else
                    w_load      = 1'b1;
                    w_state_nxt = w_is_last ? ST_DRAIN : ST_ADV1;
`endif
                end
            end
            // The sorter advances its pointer on the second of two consecutive rd_en cycles.
            ST_ADV1: begin
                sort.sort_done  = 1'b1;
                sort.sort_rd_en = 1'b1;
                w_state_nxt     = ST_ADV2;
            end
            ST_ADV2: begin
                sort.sort_done  = 1'b1;
                sort.sort_rd_en = 1'b1;
                w_state_nxt     = ST_CAPTURE;
            end
            ST_DRAIN: begin
                sort.sort_done = 1'b1;
`ifdef KNN_SKIP_EMPTY_EN
                if (w_hold_valid) begin
                    w_flush = w_free;
                end else if (m.m_valid && m.m_ready) begin
                    w_state_nxt = ST_FIN;
                end
`else
                if (m.m_valid && m.m_ready) begin
                    w_state_nxt = ST_FIN;
                end
`endif
            end
            ST_FIN: begin
                finish      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
